cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- Sequencing controller for a 2-way set-associative L1 cache.
- Each way is one 8-entry line array with a 9-bit tag, 128-bit line, and valid/dirty bits; writes use a write_type select, 0 = fill (clean), 1 = CPU modify (dirty).
- Sits between the LC-3b CPU memory port (16-bit words) and physical memory (128-bit lines).
- Detects hits, selects the LRU victim, writes back dirty victims, refills lines, merges CPU byte writes, and keeps hit/miss statistics.

Parameters:
- NUM_SETS, 8, sets per way; the index is log2(NUM_SETS) = 3 bits.
- CNT_W, 16, width of the saturating hit/miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  byte lanes for a write; [0] = low byte.
- mem_address  in  16  byte address, split as tag[15:7], index[6:4], word[3:1].
- mem_wdata  in  16  CPU write data.
- mem_rdata  out  16  selected word of the hit line.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line-read request; held until pmem_resp.
- pmem_write  out  1  line-write request; held until pmem_resp.
- pmem_address  out  16  line address; low 4 bits always 0.
- pmem_wdata  out  128  victim line.
- pmem_rdata  in  128  fill line.
- pmem_resp  in  1  physical-memory completion pulse.
- way_valid  in  2  valid bit of each way at the current index.
- way_dirty  in  2  dirty bit of each way at the current index.
- way0_tag, way1_tag  in  9 each  stored tags.
- way0_data, way1_data  in  128 each  stored lines.
- way_load  out  2  per-way array write strobe.
- way_write_type  out  1  0 = fill, 1 = CPU modify.
- line_wdata  out  128  line written to the arrays.
- line_tag  out  9  tag written to the arrays.
- array_index  out  3  index driven to both arrays; always mem_address[6:4].
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Arrays are read combinationally. Writes happen on the posedge of clk when way_load[i]=1.
- hit[i] = way_valid[i] & (wayi_tag == mem_address[15:7]).
- If both ways hit (illegal), way 0 takes priority.
- req = mem_read | mem_write. If both are asserted, the access is treated as a write.
- Reset (async, reset_n=0):
  - state = CHECK; lru[7:0] = 0; both counters = 0.
  - All outputs 0, except array_index, which follows the address.
  - Reset mid-WRITEBACK or mid-ALLOCATE abandons the pmem transaction, drops pmem_read/pmem_write immediately, and leaves array contents untouched.
- FSM states: CHECK, WRITEBACK, ALLOCATE.
- CHECK, idle (req=0): no outputs asserted.
- CHECK, read hit:
  - mem_resp=1 combinationally in the same cycle (hit latency 1 cycle).
  - mem_rdata = hit line bits [16*word +: 16].
- CHECK, write hit:
  - mem_resp=1; way_load[hit way]=1; way_write_type=1; line_tag = request tag.
  - line_wdata = hit line with only the enabled byte lanes of word `word` replaced by mem_wdata.
  - byte_enable=00 still sets dirty and responds.
- CHECK, any hit, on the clock edge: lru[index] <= ~hit_way; hit_count += 1, saturating at all-ones.
- CHECK, miss:
  - victim = lru[index]; miss_count += 1 (saturating).
  - Go to WRITEBACK if way_valid[victim] & way_dirty[victim]; otherwise go to ALLOCATE.
  - Only the miss cycle counts; the post-fill re-hit increments hit_count.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 4'b0}; pmem_wdata = victim line.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1; pmem_address = {request tag, index, 4'b0}.
  - On pmem_resp, in the same cycle: way_load[victim]=1, way_write_type=0, line_wdata=pmem_rdata, line_tag=request tag. Then go to CHECK.
- After a fill, the next CHECK cycle hits; miss latency = pmem latency(s) + 2 cycles.
- The victim is registered on CHECK→WRITEBACK/ALLOCATE and is not recomputed.
- A request deasserted mid-miss does not cancel: the fill completes and no mem_resp is issued.
- mem_resp is never asserted outside CHECK. pmem_read and pmem_write are never asserted together.

Decomposition:
- lc3b_types package already provides lc3b_word, lc3b_cache_tag, lc3b_cache_index, and lc3b_pmem_line. Add:
  - lc3b_cache_offset (3-bit word select).
  - cache_ctrl_state_t enum {CHECK, WRITEBACK, ALLOCATE}.
- Sub-module lru_array: NUM_SETS×1-bit register file, async reset to 0. Read port at the index; write port (load, index, din).
- Counters and byte-merge logic stay inline.

Test Plan:
- Reset, then read 0x0010 (all lines invalid, pmem returns line 0x...BEEF_CAFE) → pmem_read addr 0x0010; fill into way 0; mem_resp the cycle after pmem_resp; mem_rdata=0xCAFE; miss_count=1, hit_count=1; lru[1]=1.
- Read 0x0012, same line → mem_resp in the request cycle; rdata = word 1; no pmem activity.
- Write 0x0012, data 0xAB12, byte_enable=10 → way_load=01, write_type=1; only byte 3 of the line becomes 0xAB; the next read of 0x0012 returns the merged word.
- Fill way 1 at index 1 (address 0x0090), then read 0x0110 → victim way 0 (dirty) is written back to 0x0010 with the merged line; then pmem_read 0x0110.
- Assert reset_n=0 for one cycle mid-ALLOCATE → pmem_read drops at once, state=CHECK, counters=0; a re-issued read completes normally.
- Force hit_count to 0xFFFF via 65535 hits, then one more hit → hit_count stays 0xFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types plus the cache controller's state encoding
// and byte-merge helper.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [8:0]   lc3b_cache_tag;
    typedef logic [2:0]   lc3b_cache_index;
    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [2:0]   lc3b_cache_offset;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        ALLOCATE
    } cache_ctrl_state_t;

    // Replace only the enabled byte lanes of one 16-bit word inside a line.
    function automatic lc3b_pmem_line merge_word(
        input lc3b_pmem_line    line,
        input lc3b_cache_offset word,
        input logic [1:0]       byte_enable,
        input lc3b_word         data
    );
        lc3b_pmem_line merged;
        merged = line;
        if (byte_enable[0]) merged[16*word +: 8]     = data[7:0];
        if (byte_enable[1]) merged[16*word + 8 +: 8] = data[15:8];
        return merged;
    endfunction

endpackage

// File: rtl/cache_control_lru.sv
// One LRU bit per set: the stored bit names the way to evict next.
module lru_array #(
    parameter  int NUM_SETS = 8,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [IDX_W-1:0] index,
    input  logic             din,
    output logic             dout
);

    logic [NUM_SETS-1:0] lru_bits;

    // NOTE: this array is only NUM_SETS flops, so it is reset with everything
    // else; a large RAM-backed array would be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lru_bits <= '0;
        end else if (load) begin
            lru_bits[index] <= din;
        end
    end

    assign dout = lru_bits[index];

endmodule

// File: rtl/cache_control.sv
// Sequencing controller for a 2-way set-associative L1 cache: hit detection,
// LRU victim selection, dirty write-back, line refill and hit/miss statistics.
module cache_control
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       mem_byte_enable,
    input  logic [15:0]      mem_address,
    input  logic [15:0]      mem_wdata,
    output logic [15:0]      mem_rdata,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic [127:0]     pmem_wdata,
    input  logic [127:0]     pmem_rdata,
    input  logic             pmem_resp,
    input  logic [1:0]       way_valid,
    input  logic [1:0]       way_dirty,
    input  logic [8:0]       way0_tag,
    input  logic [8:0]       way1_tag,
    input  logic [127:0]     way0_data,
    input  logic [127:0]     way1_data,
    output logic [1:0]       way_load,
    output logic             way_write_type,
    output logic [127:0]     line_wdata,
    output logic [8:0]       line_tag,
    output logic [2:0]       array_index,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    cache_ctrl_state_t state;
    logic              victim;
    logic              req;
    logic [1:0]        hit;
    logic              any_hit;
    logic              hit_way;
    logic              lru_bit;
    logic              lru_load;
    lc3b_cache_tag     req_tag;
    lc3b_cache_index   index;
    lc3b_cache_offset  word;
    lc3b_pmem_line     hit_line;
    lc3b_pmem_line     victim_line;
    lc3b_cache_tag     victim_tag;
    logic              unused_byte_bit;

    assign req_tag         = mem_address[15:7];
    assign index           = mem_address[6:4];
    assign word            = mem_address[3:1];
    assign unused_byte_bit = mem_address[0];
    assign array_index     = index;

    assign req     = mem_read | mem_write;
    assign hit[0]  = way_valid[0] & (way0_tag == req_tag);
    assign hit[1]  = way_valid[1] & (way1_tag == req_tag);
    assign any_hit = |hit;
    // Way 0 wins if both ways claim the tag.
    assign hit_way  = ~hit[0];
    assign hit_line = hit[0] ? way0_data : way1_data;

    assign victim_line = victim ? way1_data : way0_data;
    assign victim_tag  = victim ? way1_tag  : way0_tag;

    assign lru_load = (state == CHECK) & req & any_hit;

    lru_array #(.NUM_SETS(NUM_SETS)) u_lru (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lru_load),
        .index   (index),
        .din     (~hit_way),
        .dout    (lru_bit)
    );

    // Outputs decode straight from state so a hit responds in its own cycle
    // and an async reset drops every strobe at once.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        mem_rdata      = '0;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = '0;
        pmem_wdata     = '0;
        way_load       = '0;
        way_write_type = 1'b0;
        line_wdata     = '0;
        line_tag       = '0;
        if (reset_n) begin
            case (state)
                CHECK: begin
                    if (req && any_hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = hit_line[16*word +: 16];
                        if (mem_write) begin
                            way_load[hit_way] = 1'b1;
                            way_write_type    = 1'b1;
                            line_tag          = req_tag;
                            line_wdata        = merge_word(hit_line, word, mem_byte_enable, mem_wdata);
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {victim_tag, index, 4'b0000};
                    pmem_wdata   = victim_line;
                end
                ALLOCATE: begin
                    pmem_read    = 1'b1;
                    pmem_address = {req_tag, index, 4'b0000};
                    if (pmem_resp) begin
                        way_load[victim] = 1'b1;
                        line_wdata       = pmem_rdata;
                        line_tag         = req_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state and counters use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CHECK;
            victim     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                CHECK: begin
                    if (req && any_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                    end else if (req) begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        // Victim is frozen here for the whole miss sequence.
                        victim <= lru_bit;
                        state  <= (way_valid[lru_bit] & way_dirty[lru_bit]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: if (pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (pmem_resp) state <= CHECK;
                default:   state <= CHECK;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Randomized bench for cache_control: environment arrays and pmem responder,
// checked against a set/way/LRU reference model and a flat golden memory.
module tb_cache_control;
    import lc3b_types::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = '0;
    logic [15:0]  mem_address = '0, mem_wdata = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp, pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [1:0]   way_valid, way_dirty, way_load;
    logic [8:0]   way0_tag, way1_tag, line_tag;
    logic [127:0] way0_data, way1_data, line_wdata;
    logic         way_write_type;
    logic [2:0]   array_index;
    logic [15:0]  hit_count, miss_count;

    int n_checks = 0, n_errors = 0;
    int lat_min = 0, lat_max = 2, pm_wait = -1, pm_cycles = 0;

    typedef struct {bit wr; logic [15:0] addr; logic [127:0] data;} pev_t;
    pev_t ev_q[$];

    logic [127:0] gold [logic [15:0]];
    logic [127:0] pmem [logic [15:0]];

    // Environment arrays (the storage the controller sequences).
    logic [7:0]   e_valid [2] = '{8'h00, 8'h00};
    logic [7:0]   e_dirty [2] = '{8'h00, 8'h00};
    logic [8:0]   e_tag   [2][8];
    logic [127:0] e_data  [2][8];

    // Reference model state.
    bit           m_valid [8][2];
    bit           m_dirty [8][2];
    logic [8:0]   m_tag   [8][2];
    bit           m_lru   [8];
    logic [15:0]  exp_hit = 0, exp_miss = 0;
    logic [15:0]  last_rdata = 0, last_wb_addr = 16'hFFFF;

    always #5 clk = ~clk;

    cache_control dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .way_valid(way_valid), .way_dirty(way_dirty),
        .way0_tag(way0_tag), .way1_tag(way1_tag), .way0_data(way0_data), .way1_data(way1_data),
        .way_load(way_load), .way_write_type(way_write_type), .line_wdata(line_wdata),
        .line_tag(line_tag), .array_index(array_index), .hit_count(hit_count), .miss_count(miss_count)
    );

    assign way_valid = {e_valid[1][array_index], e_valid[0][array_index]};
    assign way_dirty = {e_dirty[1][array_index], e_dirty[0][array_index]};
    assign way0_tag  = e_tag[0][array_index];
    assign way1_tag  = e_tag[1][array_index];
    assign way0_data = e_data[0][array_index];
    assign way1_data = e_data[1][array_index];

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (way_load[w]) begin
                e_valid[w][array_index] <= 1'b1;
                e_dirty[w][array_index] <= way_write_type;
                e_tag[w][array_index]   <= line_tag;
                e_data[w][array_index]  <= line_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [15:0] a);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) l[16*i +: 16] = a + 16'(i) * 16'h0101;
        l[15:0]  = 16'hCAFE ^ a ^ 16'h0010;
        l[31:16] = 16'hBEEF ^ a ^ 16'h0010;
        return l;
    endfunction

    function automatic logic [127:0] gold_get(input logic [15:0] a);
        return gold.exists(a) ? gold[a] : init_line(a);
    endfunction

    function automatic logic [127:0] pm_get(input logic [15:0] a);
        return pmem.exists(a) ? pmem[a] : init_line(a);
    endfunction

    // Physical memory: random latency, one-cycle resp pulse.
    always begin
        @(negedge clk);
        #1;
        pmem_resp = 1'b0;
        if (!reset_n || !(pmem_read || pmem_write)) begin
            pm_wait = -1;
        end else begin
            check("pmem_excl", pmem_read & pmem_write, 0);
            pm_cycles++;
            if (pm_wait < 0) pm_wait = int'($urandom_range(unsigned'(lat_max), unsigned'(lat_min)));
            if (pm_wait == 0) begin
                if (pmem_write) begin
                    ev_q.push_back('{1'b1, pmem_address, pmem_wdata});
                    pmem[pmem_address] = pmem_wdata;
                end else begin
                    pmem_rdata = pm_get(pmem_address);
                    ev_q.push_back('{1'b0, pmem_address, pmem_rdata});
                end
                pmem_resp = 1'b1;
                pm_wait   = -1;
            end else begin
                pm_wait--;
            end
        end
    end

    // One CPU access, called at a negedge; returns at the negedge after mem_resp.
    task automatic do_access(input bit wr, input bit both, input logic [15:0] addr,
                             input logic [1:0] be, input logic [15:0] wd);
        logic [2:0]   set;
        logic [8:0]   tag;
        logic [15:0]  line_a, wb_a;
        logic [2:0]   w;
        logic [127:0] old_l, new_l;
        int           hw, resp_cyc;
        bit           miss, v;
        pev_t         exp_q[$];

        set = addr[6:4]; tag = addr[15:7]; w = addr[3:1];
        line_a = {addr[15:4], 4'h0};
        hw = -1; miss = 0;
        if (m_valid[set][0] && m_tag[set][0] == tag) hw = 0;
        else if (m_valid[set][1] && m_tag[set][1] == tag) hw = 1;
        if (hw < 0) begin
            miss = 1;
            v = m_lru[set];
            if (exp_miss != 16'hFFFF) exp_miss++;
            if (m_valid[set][v] && m_dirty[set][v]) begin
                wb_a = {m_tag[set][v], set, 4'h0};
                exp_q.push_back('{1'b1, wb_a, gold_get(wb_a)});
            end
            exp_q.push_back('{1'b0, line_a, gold_get(line_a)});
            m_valid[set][v] = 1; m_tag[set][v] = tag; m_dirty[set][v] = 0;
            hw = int'(v);
        end
        if (exp_hit != 16'hFFFF) exp_hit++;
        m_lru[set] = (hw == 0);
        old_l = gold_get(line_a);
        new_l = old_l;
        if (wr) begin
            if (be[0]) new_l[8*(2*w) +: 8]     = wd[7:0];
            if (be[1]) new_l[8*(2*w + 1) +: 8] = wd[15:8];
            gold[line_a] = new_l;
            m_dirty[set][hw] = 1;
        end

        ev_q.delete();
        pm_cycles = 0;
        mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
        mem_read = !wr || both; mem_write = wr;
        resp_cyc = 0;
        for (int c = 1; c <= 60 && resp_cyc == 0; c++) begin
            #3;
            if (pmem_resp && pmem_read) begin
                check("fill_strobe", {way_write_type, way_load, line_tag}, {1'b0, 2'(1 << hw), tag});
                check("fill_data", line_wdata, old_l);
            end
            if (mem_resp) begin
                resp_cyc = c;
                if (wr) begin
                    check("wr_strobe", {way_write_type, way_load, line_tag}, {1'b1, 2'(1 << hw), tag});
                    check("wr_line", line_wdata, new_l);
                end else begin
                    last_rdata = mem_rdata;
                    check("rd_data", mem_rdata, old_l[16*w +: 16]);
                    check("rd_noload", way_load, 0);
                end
            end
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0;

        check("resp_seen", resp_cyc != 0, 1);
        check("latency", resp_cyc, miss ? pm_cycles + 2 : 1);
        check("pev_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            check("pev_kind", {ev_q[i].wr, ev_q[i].addr}, {exp_q[i].wr, exp_q[i].addr});
            check("pev_data", ev_q[i].data, exp_q[i].data);
        end
        if (ev_q.size() > 0 && ev_q[0].wr) last_wb_addr = ev_q[0].addr;
        check("hit_count", hit_count, exp_hit);
        check("miss_count", miss_count, exp_miss);
    endtask

    logic [8:0] tag_pool [4] = '{9'h000, 9'h001, 9'h002, 9'h0A5};

    initial begin
        int  n;
        bit  got;
        bit  wr;

        for (int s = 0; s < 8; s++) begin
            m_lru[s] = 0;
            for (int k = 0; k < 2; k++) begin
                m_valid[s][k] = 0; m_dirty[s][k] = 0; m_tag[s][k] = '0;
            end
        end

        // Reset: request pending, outputs quiet, index follows address.
        mem_address = 16'h0010; mem_read = 1'b1;
        #3;
        check("rst_outputs", {mem_resp, pmem_read, pmem_write, way_load, way_write_type}, 0);
        check("rst_counts", {hit_count, miss_count}, 0);
        check("rst_index", array_index, 3'd1);
        @(negedge clk);
        mem_read = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #3;
        check("idle_quiet", {mem_resp, pmem_read, pmem_write, way_load}, 0);
        @(negedge clk);

        // Cold read miss, fill into way 0.
        do_access(0, 0, 16'h0010, 2'b00, 16'h0);
        check("tp_cafe", last_rdata, 16'hCAFE);
        check("tp_counts", {hit_count, miss_count}, {16'd1, 16'd1});
        do_access(0, 0, 16'h0012, 2'b00, 16'h0);
        check("tp_word1", last_rdata, 16'hBEEF);
        do_access(1, 0, 16'h0012, 2'b10, 16'hAB12);
        do_access(0, 0, 16'h0012, 2'b00, 16'h0);
        check("tp_merge", last_rdata, 16'hABEF);
        do_access(0, 0, 16'h0090, 2'b00, 16'h0);
        do_access(0, 0, 16'h0110, 2'b00, 16'h0);
        check("tp_wb_addr", last_wb_addr, 16'h0010);

        // Random traffic over a small tag pool to force conflicts.
        for (int i = 0; i < 150; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            do_access(wr, wr && ($urandom_range(0, 3) == 0),
                      {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0},
                      2'($urandom_range(0, 3)), 16'($urandom));
        end

        // Reset in the middle of ALLOCATE.
        lat_min = 4; lat_max = 4;
        mem_address = 16'hFFA0; mem_read = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            #3;
            if (pmem_read) got = 1;
            else @(negedge clk);
        end
        check("mid_alloc_seen", got, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_drop", {pmem_read, pmem_write, mem_resp, way_load}, 0);
        check("mid_rst_counts", {hit_count, miss_count}, 0);
        check("mid_rst_index", array_index, 3'd2);
        @(negedge clk);
        mem_read = 1'b0;
        reset_n = 1'b1;
        ev_q.delete();
        for (int s = 0; s < 8; s++) m_lru[s] = 0;
        exp_hit = 0; exp_miss = 0;
        lat_min = 0; lat_max = 2;
        do_access(0, 0, 16'hFFA0, 2'b00, 16'h0);
        check("post_rst_counts", {hit_count, miss_count}, {16'd1, 16'd1});

        // Saturate the hit counter by holding a read on a resident line.
        do_access(0, 0, 16'h0010, 2'b00, 16'h0);
        n = int'(16'hFFFF - exp_hit);
        mem_address = 16'h0010; mem_read = 1'b1;
        repeat (n) @(negedge clk);
        mem_read = 1'b0;
        exp_hit = 16'hFFFF;
        check("sat_reach", hit_count, 16'hFFFF);
        do_access(0, 0, 16'h0010, 2'b00, 16'h0);
        check("sat_hold", hit_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
